// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit (package fetch_pkg).
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the instruction-memory port, the decode handshake and the branch redirect.
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            br_taken;
  logic [XLEN-1:0] br_target;

  modport master (
    output imem_en, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, if_ready, br_taken, br_target
  );

  modport slave (
    input  imem_en, imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, if_ready, br_taken, br_target
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Synchronous prefetch FIFO of PC-tagged instruction words; flush beats push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  pushEntry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o,
  output fetch_entry_t  head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doPush, doPop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = nextPtr(wrPtr_q);
      if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
      count_d = count_q + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i && doPush) mem_q[wrPtr_q] <= pushEntry_i;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues reads to a 1-cycle memory, queues results for decode.
// Optional macro IF_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            holdoff_q;
  fetch_entry_t    hold_q, hold_d;

  logic [CW-1:0]   fifoCount;
  logic            fifoEmpty, fifoFull;
  fetch_entry_t    fifoHead, respEntry, outEntry;
  logic            respValid, bypassTake, ifValid;
  logic            pop, fifoPop, push, issue;
  logic [CW:0]     occupancy;

  assign respValid       = inflight_q && !bus.br_taken;
  assign respEntry.pc    = req_pc_q;
  assign respEntry.instr = bus.imem_rdata;

  // Head selection; with the FIFO empty the last presented entry is held.
  always_comb begin
    outEntry   = hold_q;
    ifValid    = 1'b0;
    bypassTake = 1'b0;
    if (rst) begin
      outEntry = '0;
    end else if (!fifoEmpty) begin
      outEntry = fifoHead;
      ifValid  = 1'b1;
    end
`ifdef IF_BYPASS_EN
    else if (respValid) begin
      outEntry   = respEntry;
      ifValid    = 1'b1;
      bypassTake = bus.if_ready;
    end
`endif
  end

  assign hold_d       = outEntry;
  assign bus.if_valid = ifValid;
  assign bus.if_pc    = outEntry.pc;
  assign bus.if_instr = outEntry.instr;

  assign pop     = ifValid && bus.if_ready;
  assign fifoPop = !fifoEmpty && bus.if_ready;
  assign push    = respValid && !bypassTake;

  // Credit check: queued plus in-flight entries, less the one leaving now, must leave room.
  assign occupancy = {1'b0, fifoCount} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = !rst && !holdoff_q && !bus.br_taken && (occupancy < (CW+1)'(DEPTH));

  assign bus.imem_en   = issue;
  assign bus.imem_addr = rst ? RESET_PC : pc_q;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (bus.br_taken) begin
      pc_d = bus.br_target & ~XLEN'(INSTR_BYTES - 1);
    end else if (issue) begin
      pc_d     = pc_q + XLEN'(INSTR_BYTES);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      holdoff_q  <= 1'b1;
      hold_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      holdoff_q  <= 1'b0;
      hold_q     <= hold_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pushEntry_i(respEntry),
    .pop_i      (fifoPop),
    .flush_i    (bus.br_taken),
    .count_o    (fifoCount),
    .empty_o    (fifoEmpty),
    .full_o     (fifoFull),
    .head_o     (fifoHead)
  );

  assert property (@(posedge clk) disable iff (rst) !(push && fifoFull));

endmodule
